// File: rtl/la_pkg.sv
// Shared types and sizing helpers for the logic-analyzer capture path.
package la_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } ser_state_t;

    localparam int BYTE_W    = 8;
    localparam int BYTE_IDX_W = 2;

    function automatic int bytes_per_sample(input int sample_width);
        return sample_width / BYTE_W;
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/la_sample_fifo.sv
// Single-clock sample FIFO with first-word-fall-through read data.
module la_sample_fifo
    import la_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PW = ptr_width(DEPTH),
    localparam int AW = PW - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == PW'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ft245_capture_streamer.sv
// Samples a synchronised probe bus at a decimated rate, buffers the samples
// and streams them LSB byte first into an FT245 write-only FIFO interface.
module ft245_capture_streamer
    import la_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [DIV_WIDTH-1:0]        div_ratio,
    input  logic [SAMPLE_WIDTH-1:0]     capture,
    output logic [7:0]                  data,
    input  logic                        txe_n,
    input  logic                        rxf_n,
    output logic                        wr_n,
    output logic                        rd_n,
    output logic                        oe_n,
    output logic                        siwu_n,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int NB = bytes_per_sample(SAMPLE_WIDTH);

    logic [SAMPLE_WIDTH-1:0] sync1;
    logic [SAMPLE_WIDTH-1:0] capture_s;
    logic [DIV_WIDTH-1:0]    div_cnt;
    logic [DIV_WIDTH-1:0]    div_limit;
    logic                    strobe;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [SAMPLE_WIDTH-1:0] fifo_dout;
    logic [SAMPLE_WIDTH-1:0] sr;
    logic [BYTE_IDX_W-1:0]   byte_idx;
    logic                    last_byte;
    ser_state_t              state;
    ser_state_t              state_next;
    logic                    unused_rxf;

    assign rd_n       = 1'b1;
    assign oe_n       = 1'b1;
    assign siwu_n     = 1'b1;
    assign unused_rxf = rxf_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            capture_s <= '0;
        end else begin
            sync1     <= capture;
            capture_s <= sync1;
        end
    end

    // The period limit is captured only at a wrap (or while idle), so a new
    // div_ratio never truncates or stretches the period already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            div_limit <= '0;
        end else if (!enable) begin
            div_cnt   <= '0;
            div_limit <= div_ratio;
        end else if (div_cnt == div_limit) begin
            div_cnt   <= '0;
            div_limit <= div_ratio;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign strobe = enable && (div_cnt == '0);

    la_sample_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (strobe),
        .pop   (pop),
        .din   (capture_s),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (strobe && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    assign last_byte = (byte_idx == BYTE_IDX_W'(NB - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = SETUP;
            SETUP:   if (!txe_n) state_next = STROBE;
            STROBE:  state_next = HOLD;
            HOLD:    state_next = last_byte ? IDLE : SETUP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop  = (state == IDLE) && !fifo_empty;
        wr_n = (state != STROBE);
    end

    // The shift register keeps its last byte after the final HOLD so data
    // stays put while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            byte_idx <= '0;
        end else if (pop) begin
            sr       <= fifo_dout;
            byte_idx <= '0;
        end else if (state == HOLD && !last_byte) begin
            sr       <= sr >> 8;
            byte_idx <= byte_idx + 1'b1;
        end
    end

    assign data = sr[7:0];

endmodule
